// File: rtl/branch_predict_ctrl_if.sv
// Fetch/decode/resolve bundle for branch_predict_ctrl.
// master = fetch/execute side driving instructions and resolutions, slave = the predictor.
interface branch_predict_ctrl_if #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned INSTR_W     = 14,
  parameter int unsigned QUEUE_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;
  logic               resolve_valid;
  logic               resolve_taken;

  logic [ADDR_W-1:0]  next_pc;
  logic               next_valid;
  logic               redirect;
  logic               predict_taken;
  logic               flush;
  logic               stall;
  logic               resolve_err;
  logic [CNT_W-1:0]   q_count;
  logic [15:0]        stat_branches;
  logic [15:0]        stat_mispredicts;

  modport master (
    output instr_valid, instr, pc, resolve_valid, resolve_taken,
    input  next_pc, next_valid, redirect, predict_taken, flush, stall,
           resolve_err, q_count, stat_branches, stat_mispredicts
  );

  modport slave (
    input  instr_valid, instr, pc, resolve_valid, resolve_taken,
    output next_pc, next_valid, redirect, predict_taken, flush, stall,
           resolve_err, q_count, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Jump/branch decode with 2-bit counter prediction and an in-order resolve queue.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_ctrl #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned COND_W      = 2,
  parameter int unsigned INSTR_W     = 14,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  branch_predict_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TBL_N = 2 ** IDX_W;

  // Predictor table and queue storage
  logic [1:0]        ctr_q   [TBL_N];
  logic              qpred_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0] qalt_q  [QUEUE_DEPTH];
  logic [IDX_W-1:0]  qidx_q  [QUEUE_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              next_valid_q, next_valid_d;
  logic              redirect_q, redirect_d;
  logic              predict_taken_q, predict_taken_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              resolve_err_q, resolve_err_d;

  logic              is_branch, is_cond, pred;
  logic [COND_W-1:0] cond;
  logic [ADDR_W-1:0] target, seq;
  logic [IDX_W-1:0]  rd_idx;
  logic              head_pred;
  logic [ADDR_W-1:0] head_alt;
  logic [IDX_W-1:0]  head_idx;
  logic [1:0]        head_ctr, ctr_upd;
  logic              pop, mispredict, accept, push;

  always_comb begin
    is_branch = bus.instr[INSTR_W-1];
    cond      = bus.instr[ADDR_W+COND_W-1:ADDR_W];
    target    = bus.instr[ADDR_W-1:0];
    seq       = bus.pc + ADDR_W'(1);
    rd_idx    = bus.pc[IDX_W-1:0];
    is_cond   = is_branch && (cond != '0);
    pred      = ctr_q[rd_idx][1];
  end

  // Resolve side: oldest entry and its counter update
  always_comb begin
    head_pred  = qpred_q[rd_ptr_q];
    head_alt   = qalt_q[rd_ptr_q];
    head_idx   = qidx_q[rd_ptr_q];
    head_ctr   = ctr_q[head_idx];
    pop        = bus.resolve_valid && (count_q != '0);
    mispredict = pop && (bus.resolve_taken != head_pred);
    if (bus.resolve_taken) ctr_upd = (head_ctr == 2'd3) ? 2'd3 : head_ctr + 2'd1;
    else                   ctr_upd = (head_ctr == 2'd0) ? 2'd0 : head_ctr - 2'd1;
  end

  // A correctly predicted pop frees a slot this cycle, so a full queue may still accept
  always_comb begin
    accept = bus.instr_valid && (!stall_q || (pop && !mispredict));
    push   = accept && is_cond && !mispredict;
  end

  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    next_pc_d       = next_pc_q;
    next_valid_d    = 1'b0;
    redirect_d      = 1'b0;
    predict_taken_d = predict_taken_q;
    flush_d         = mispredict;
    resolve_err_d   = bus.resolve_valid && (count_q == '0);

    if (mispredict) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      next_valid_d = 1'b1;
      redirect_d   = 1'b1;
      next_pc_d    = head_alt;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (accept) begin
        next_valid_d = 1'b1;
        if (!is_branch) begin
          next_pc_d  = seq;
          redirect_d = 1'b0;
        end else if (!is_cond) begin
          next_pc_d  = target;
          redirect_d = 1'b1;
        end else begin
          next_pc_d       = pred ? target : seq;
          redirect_d      = pred;
          predict_taken_d = pred;
        end
      end
    end
    stall_d = (count_d == CNT_W'(QUEUE_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TBL_N; i++) ctr_q[i] <= 2'b01;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        qpred_q[i] <= 1'b0;
        qalt_q[i]  <= '0;
        qidx_q[i]  <= '0;
      end
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      next_pc_q       <= '0;
      next_valid_q    <= 1'b0;
      redirect_q      <= 1'b0;
      predict_taken_q <= 1'b0;
      flush_q         <= 1'b0;
      stall_q         <= 1'b0;
      resolve_err_q   <= 1'b0;
    end else begin
      if (pop) ctr_q[head_idx] <= ctr_upd;
      if (push) begin
        qpred_q[wr_ptr_q] <= pred;
        qalt_q[wr_ptr_q]  <= pred ? seq : target;
        qidx_q[wr_ptr_q]  <= rd_idx;
      end
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      next_pc_q       <= next_pc_d;
      next_valid_q    <= next_valid_d;
      redirect_q      <= redirect_d;
      predict_taken_q <= predict_taken_d;
      flush_q         <= flush_d;
      stall_q         <= stall_d;
      resolve_err_q   <= resolve_err_d;
    end
  end

  assign bus.next_pc       = next_pc_q;
  assign bus.next_valid    = next_valid_q;
  assign bus.redirect      = redirect_q;
  assign bus.predict_taken = predict_taken_q;
  assign bus.flush         = flush_q;
  assign bus.stall         = stall_q;
  assign bus.resolve_err   = resolve_err_q;
  assign bus.q_count       = count_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_br_q, stat_mp_q;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (accept && is_cond && (stat_br_q != 16'hFFFF)) stat_br_q <= stat_br_q + 16'd1;
      if (mispredict && (stat_mp_q != 16'hFFFF))        stat_mp_q <= stat_mp_q + 16'd1;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: queue-based reference model checked every cycle plus directed literals.
module tb_branch_predict_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_ctrl_if #(.ADDR_W(11), .INSTR_W(14), .QUEUE_DEPTH(DEPTH)) bif ();

  branch_predict_ctrl #(
    .ADDR_W(11), .COND_W(2), .INSTR_W(14), .IDX_W(4), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of pending predictions and an integer counter table
  typedef struct { logic pred; logic [10:0] alt; int idx; } ent_t;
  ent_t mq[$];
  int   ctr[16];

  logic [10:0] e_pc, sq, tgt;
  logic        e_nv, e_rd, e_pt, e_fl, e_st, e_err;
  int          e_cnt, e_sb, e_sm, n, hi;
  logic        m_pop, m_mis, m_acc, m_cond, m_pred, br;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 16; i++) ctr[i] = 1;
      e_pc = 0; e_nv = 0; e_rd = 0; e_pt = 0; e_fl = 0; e_st = 0; e_err = 0;
      e_cnt = 0; e_sb = 0; e_sm = 0;
    end else begin
      n      = mq.size();
      m_pop  = bif.resolve_valid && (n > 0);
      m_mis  = m_pop && (bif.resolve_taken != mq[0].pred);
      m_acc  = bif.instr_valid && ((n < DEPTH) || (m_pop && !m_mis));
      br     = bif.instr[13];
      m_cond = br && (bif.instr[12:11] != 2'b00);
      tgt    = bif.instr[10:0];
      sq     = bif.pc + 11'd1;
      m_pred = ctr[bif.pc % 16] >= 2;
      e_fl   = m_mis;
      e_err  = bif.resolve_valid && (n == 0);
      if (m_mis) begin
        e_nv = 1; e_rd = 1; e_pc = mq[0].alt;
      end else if (m_acc) begin
        e_nv = 1;
        if (!br)          begin e_pc = sq;  e_rd = 0; end
        else if (!m_cond) begin e_pc = tgt; e_rd = 1; end
        else begin e_pc = m_pred ? tgt : sq; e_rd = m_pred; end
      end else begin
        e_nv = 0; e_rd = 0;
      end
      if (m_pop) begin
        hi = mq[0].idx;
        if (bif.resolve_taken) ctr[hi] = (ctr[hi] == 3) ? 3 : ctr[hi] + 1;
        else                   ctr[hi] = (ctr[hi] == 0) ? 0 : ctr[hi] - 1;
      end
`ifdef BRANCH_STATS_EN
      if (m_acc && m_cond && e_sb < 65535) e_sb++;
      if (m_mis && e_sm < 65535) e_sm++;
`endif
      if (m_mis) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_acc && m_cond) begin
          mq.push_back('{pred: m_pred, alt: (m_pred ? sq : tgt), idx: int'(bif.pc % 16)});
          e_pt = m_pred;
        end
      end
      e_cnt = mq.size();
      e_st  = (e_cnt == DEPTH);
    end
  end

  // Every-cycle compare against the model, away from the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_next_valid", 32'(bif.next_valid), 32'(e_nv));
      chk("m_next_pc",    32'(bif.next_pc),    32'(e_pc));
      chk("m_redirect",   32'(bif.redirect),   32'(e_rd));
      chk("m_pred_taken", 32'(bif.predict_taken), 32'(e_pt));
      chk("m_flush",      32'(bif.flush),      32'(e_fl));
      chk("m_stall",      32'(bif.stall),      32'(e_st));
      chk("m_res_err",    32'(bif.resolve_err), 32'(e_err));
      chk("m_q_count",    32'(bif.q_count),    32'(e_cnt));
      chk("m_stat_br",    32'(bif.stat_branches),    32'(e_sb));
      chk("m_stat_mp",    32'(bif.stat_mispredicts), 32'(e_sm));
    end
  end

  task automatic drive(input logic iv, input logic [13:0] in, input logic [10:0] p,
                       input logic rv, input logic rt);
    bif.instr_valid   = iv;
    bif.instr         = in;
    bif.pc            = p;
    bif.resolve_valid = rv;
    bif.resolve_taken = rt;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 14'h0, 11'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bif.instr_valid = 0; bif.instr = 0; bif.pc = 0;
    bif.resolve_valid = 0; bif.resolve_taken = 0;
    repeat (3) @(negedge clk);
    chk("rst_next_pc", 32'(bif.next_pc), 32'h0);
    chk("rst_q_count", 32'(bif.q_count), 32'h0);
    chk("rst_stall",   32'(bif.stall), 32'h0);
    chk("rst_valid",   32'(bif.next_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    drive(1, 14'h0005, 11'h010, 0, 0);
    chk("seq_valid", 32'(bif.next_valid), 32'h1);
    chk("seq_pc",    32'(bif.next_pc), 32'h011);
    chk("seq_redir", 32'(bif.redirect), 32'h0);

    drive(1, 14'h2123, 11'h020, 0, 0);
    chk("jmp_pc",    32'(bif.next_pc), 32'h123);
    chk("jmp_redir", 32'(bif.redirect), 32'h1);
    chk("jmp_qcnt",  32'(bif.q_count), 32'h0);

    drive(1, 14'h2A40, 11'h030, 0, 0);
    chk("br0_pred", 32'(bif.predict_taken), 32'h0);
    chk("br0_pc",   32'(bif.next_pc), 32'h031);
    chk("br0_qcnt", 32'(bif.q_count), 32'h1);

    drive(0, 14'h0, 11'h0, 1, 1);
    chk("mis0_flush", 32'(bif.flush), 32'h1);
    chk("mis0_pc",    32'(bif.next_pc), 32'h240);
    chk("mis0_qcnt",  32'(bif.q_count), 32'h0);
    idle();
    chk("flush_pulse", 32'(bif.flush), 32'h0);
    chk("hold_pc",     32'(bif.next_pc), 32'h240);

    // Counter walks 2 -> 3 -> 3 (saturate) under repeated taken resolves
    for (int k = 0; k < 3; k++) begin
      drive(1, 14'h2A40, 11'h030, 0, 0);
      chk("rep_pc", 32'(bif.next_pc), 32'h240);
      drive(0, 14'h0, 11'h0, 1, 1);
      chk("rep_noflush", 32'(bif.flush), 32'h0);
    end
    drive(1, 14'h2A40, 11'h030, 0, 0);
    drive(0, 14'h0, 11'h0, 1, 0);
    chk("nt_flush", 32'(bif.flush), 32'h1);
    chk("nt_pc",    32'(bif.next_pc), 32'h031);
    drive(1, 14'h2A40, 11'h030, 0, 0);
    chk("nowrap_pc", 32'(bif.next_pc), 32'h240);
    drive(0, 14'h0, 11'h0, 1, 1);

    // Fill the queue
    for (int k = 1; k <= 4; k++) drive(1, 14'h2A40, 11'(32'h040 + k), 0, 0);
    chk("full_qcnt",  32'(bif.q_count), 32'h4);
    chk("full_stall", 32'(bif.stall), 32'h1);
    drive(1, 14'h0005, 11'h050, 0, 0);
    chk("ign_valid", 32'(bif.next_valid), 32'h0);
    chk("ign_qcnt",  32'(bif.q_count), 32'h4);
    drive(1, 14'h2A40, 11'h045, 1, 0);
    chk("pp_qcnt",  32'(bif.q_count), 32'h4);
    chk("pp_pc",    32'(bif.next_pc), 32'h046);
    chk("pp_stall", 32'(bif.stall), 32'h1);
    repeat (4) drive(0, 14'h0, 11'h0, 1, 0);
    chk("drain_qcnt", 32'(bif.q_count), 32'h0);

    drive(0, 14'h0, 11'h0, 1, 0);
    chk("err_pulse", 32'(bif.resolve_err), 32'h1);
    chk("err_noflush", 32'(bif.flush), 32'h0);
    idle();
    chk("err_clear", 32'(bif.resolve_err), 32'h0);

    drive(1, 14'h0005, 11'h7FF, 0, 0);
    chk("wrap_pc", 32'(bif.next_pc), 32'h000);

    // Mispredict with a simultaneous push: recovery wins, push dropped
    drive(1, 14'h2A40, 11'h060, 0, 0);
    chk("mp_pred_pc", 32'(bif.next_pc), 32'h240);
    drive(1, 14'h2A40, 11'h070, 1, 0);
    chk("mp_push_flush", 32'(bif.flush), 32'h1);
    chk("mp_push_pc",    32'(bif.next_pc), 32'h061);
    chk("mp_push_qcnt",  32'(bif.q_count), 32'h0);
    idle();

    // Asynchronous reset mid-operation
    drive(1, 14'h2A40, 11'h033, 0, 0);
    bif.instr_valid = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_qcnt",  32'(bif.q_count), 32'h0);
    chk("arst_flush", 32'(bif.flush), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Mixed pseudo-random traffic, checked by the model
    for (int k = 0; k < 400; k++)
      drive(1'($urandom_range(0, 1)), 14'($urandom), 11'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
